// File: rtl/flash_bus_responder_if.sv
// Handshake bundle between the flash manager and the flash responder.
// FL_FLOW/FL_ADDR/fb_start come from the manager; fb_done from the responder.
interface flash_bus_responder_if;
   logic       FL_FLOW;
   logic [7:0] FL_ADDR;
   logic       fb_start;
   logic       fb_done;

   modport master (
      output FL_FLOW,
      output FL_ADDR,
      output fb_start,
      input  fb_done
   );

   modport slave (
      input  FL_FLOW,
      input  FL_ADDR,
      input  fb_start,
      output fb_done
   );
endinterface

// File: rtl/flash_bus_responder.sv
// Responder end of the FL_* flash bus: 256x8 store, emulated access latency,
// read data driven on FL_DATA after fb_done, plus a display read side port.
// Ports: CLK_50MHZ, RST (sync, active-high), fb (handshake bundle, slave),
//   FL_DATA (shared data bus), busy, overrun (sticky), disp_addr/disp_data
//   (registered display read), wr_count (saturating completed-write count).
module flash_bus_responder #(
   parameter int         ACCESS_LAT   = 4,
   parameter int         DRIVE_CYCLES = 2,
   parameter logic [7:0] INIT_BYTE    = 8'h00
) (
   input  logic                        CLK_50MHZ,
   input  logic                        RST,
   flash_bus_responder_if.slave        fb,
   inout  wire  [7:0]                  FL_DATA,
   output logic                        busy,
   output logic                        overrun,
   input  logic [7:0]                  disp_addr,
   output logic [7:0]                  disp_data,
   output logic [7:0]                  wr_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE,
      S_DRIVE
   } state_t;

   localparam logic [7:0] LAT_LOAD = 8'(ACCESS_LAT - 1);
   localparam logic [7:0] DRV_LOAD = 8'(DRIVE_CYCLES - 1);

   state_t     state;
   logic [7:0] lat_cnt;
   logic [7:0] drv_cnt;
   logic       drive_q;

   logic       flow_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;

   // Preloaded at configuration; reset deliberately leaves it alone.
   logic [7:0] mem [256] = '{default: INIT_BYTE};

   logic       accept;
   logic       acc_end;

   assign accept  = (state == S_IDLE) && fb.fb_start;
   assign acc_end = (state == S_ACCESS) && (lat_cnt == 8'd0);
   assign busy    = (state != S_IDLE);

   // RST gates the driver directly so the bus is freed in the reset cycle.
   assign FL_DATA = (drive_q && !RST) ? rdata_q : 8'bz;

   // Control FSM and registered outputs.
   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         state      <= S_IDLE;
         lat_cnt    <= 8'd0;
         drv_cnt    <= 8'd0;
         drive_q    <= 1'b0;
         fb.fb_done <= 1'b0;
         overrun    <= 1'b0;
         wr_count   <= 8'd0;
         disp_data  <= 8'd0;
      end else begin
         fb.fb_done <= 1'b0;
         disp_data  <= mem[disp_addr];
         if (fb.fb_start && state != S_IDLE) begin
            overrun <= 1'b1;
         end
         unique case (state)
            S_IDLE: begin
               if (fb.fb_start) begin
                  lat_cnt <= LAT_LOAD;
                  state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (lat_cnt == 8'd0) begin
                  fb.fb_done <= 1'b1;
                  state      <= S_DONE;
                  if (!flow_q && wr_count != 8'hFF) begin
                     wr_count <= wr_count + 8'd1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 8'd1;
               end
            end
            S_DONE: begin
               // Manager still owns FL_DATA here; drive starts next cycle.
               if (flow_q) begin
                  drive_q <= 1'b1;
                  drv_cnt <= DRV_LOAD;
                  state   <= S_DRIVE;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DRIVE: begin
               if (drv_cnt == 8'd0) begin
                  drive_q <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  drv_cnt <= drv_cnt - 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Request capture; only an IDLE-state start is taken.
   always_ff @(posedge CLK_50MHZ) begin
      if (!RST && accept) begin
         flow_q  <= fb.FL_FLOW;
         addr_q  <= fb.FL_ADDR;
         wdata_q <= FL_DATA;
      end
   end

   // Store access on the last ACCESS edge; a reset edge drops it.
   always_ff @(posedge CLK_50MHZ) begin
      if (!RST && acc_end) begin
         if (flow_q) begin
            rdata_q <= mem[addr_q];
         end else begin
            mem[addr_q] <= wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_flash_bus_responder.sv
// Self-checking bench for flash_bus_responder: directed and random accesses
// compared cycle by cycle against an array-based model of the store.
module tb_flash_bus_responder;

   localparam int LAT = 4;
   localparam int DRV = 2;

   logic       clk = 1'b0;
   logic       RST;
   logic       drv_en;
   logic [7:0] drv_data;
   logic [7:0] disp_addr;
   logic [7:0] disp_data;
   logic [7:0] wr_count;
   logic       busy;
   logic       overrun;
   wire  [7:0] FL_DATA;

   flash_bus_responder_if bus ();

   // Manager side driver; pullups make an idle bus read as 8'hFF.
   assign FL_DATA = drv_en ? drv_data : 8'bz;
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (FL_DATA[i]);
   end

   flash_bus_responder #(
      .ACCESS_LAT   (LAT),
      .DRIVE_CYCLES (DRV),
      .INIT_BYTE    (8'h00)
   ) dut (
      .CLK_50MHZ (clk),
      .RST       (RST),
      .fb        (bus),
      .FL_DATA   (FL_DATA),
      .busy      (busy),
      .overrun   (overrun),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .wr_count  (wr_count)
   );

   always #10 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] mdl [256];
   int         m_wr;
   logic       m_ovr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access; extra>0 pulses a stray fb_start in that cycle.
   task automatic run_access(input bit flow, input logic [7:0] a,
                             input logic [7:0] d, input int extra);
      logic [7:0] expr;
      logic [7:0] exp_bus;
      logic [7:0] exp_disp;
      int         last_busy;
      expr      = mdl[a];
      last_busy = LAT + 1 + (flow ? DRV : 0);
      @(posedge clk); #1;
      bus.FL_FLOW  = flow;
      bus.FL_ADDR  = a;
      bus.fb_start = 1'b1;
      drv_en       = !flow;
      drv_data     = d;
      for (int c = 1; c <= LAT + DRV + 3; c++) begin
         @(posedge clk); #1;
         bus.fb_start = (c == extra);
         if (c == extra) begin
            bus.FL_ADDR = ~a;
            drv_data    = ~d;
         end
         if (c == LAT + 2) drv_en = 1'b0;
         @(negedge clk);
         chk($sformatf("fb_done a=%0h c=%0d", a, c), bus.fb_done,
             32'(c == LAT + 1));
         chk($sformatf("busy a=%0h c=%0d", a, c), busy,
             32'(c <= last_busy));
         if (drv_en)
            exp_bus = drv_data;
         else if (flow && c >= LAT + 2 && c <= LAT + 1 + DRV)
            exp_bus = expr;
         else
            exp_bus = 8'hFF;
         chk($sformatf("bus a=%0h c=%0d", a, c), FL_DATA, exp_bus);
         if (!flow && disp_addr == a && c >= LAT + 2)
            exp_disp = d;
         else
            exp_disp = mdl[disp_addr];
         chk($sformatf("disp c=%0d", c), disp_data, exp_disp);
      end
      bus.fb_start = 1'b0;
      if (extra >= 1 && extra <= last_busy) m_ovr = 1'b1;
      if (!flow) begin
         mdl[a] = d;
         if (m_wr < 255) m_wr++;
      end
      chk("overrun", overrun, m_ovr);
      chk("wr_count", wr_count, m_wr);
   endtask

   task automatic disp_chk(input logic [7:0] a);
      @(posedge clk); #1;
      disp_addr = a;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("disp_sweep a=%0h", a), disp_data, mdl[a]);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rd;
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      m_wr         = 0;
      m_ovr        = 1'b0;
      RST          = 1'b1;
      drv_en       = 1'b0;
      drv_data     = 8'h00;
      disp_addr    = 8'h00;
      bus.FL_FLOW  = 1'b0;
      bus.FL_ADDR  = 8'h00;
      bus.fb_start = 1'b0;
      repeat (3) @(posedge clk);
      #1 RST = 1'b0;
      @(negedge clk);
      chk("rst fb_done", bus.fb_done, 0);
      chk("rst busy", busy, 0);
      chk("rst overrun", overrun, 0);
      chk("rst wr_count", wr_count, 0);
      chk("rst disp_data", disp_data, 0);
      chk("rst bus", FL_DATA, 8'hFF);

      // Write, read back, read never-written top address.
      run_access(1'b0, 8'h10, 8'hA5, 0);
      run_access(1'b1, 8'h10, 8'h00, 0);
      run_access(1'b1, 8'hFF, 8'h00, 0);

      // Stray start mid-access, then one on the last DRIVE cycle.
      run_access(1'b0, 8'h40, 8'h3C, 2);
      run_access(1'b1, 8'h40, 8'h00, LAT + 1 + DRV);
      disp_chk(8'h40);
      disp_chk(8'hBF);

      // Display reads the address being written: old, then new.
      run_access(1'b0, 8'h20, 8'h11, 0);
      @(posedge clk); #1 disp_addr = 8'h20;
      run_access(1'b0, 8'h20, 8'h22, 0);
      run_access(1'b0, 8'h20, 8'h11, 0);

      // Reset in ACCESS cycle 2 of a write drops it.
      @(posedge clk); #1;
      bus.FL_FLOW  = 1'b0;
      bus.FL_ADDR  = 8'h20;
      bus.fb_start = 1'b1;
      drv_en       = 1'b1;
      drv_data     = 8'hEE;
      @(posedge clk); #1 bus.fb_start = 1'b0;
      @(posedge clk); #1 RST = 1'b1;
      @(posedge clk); #1;
      RST    = 1'b0;
      drv_en = 1'b0;
      m_wr   = 0;
      m_ovr  = 1'b0;
      @(negedge clk);
      chk("abort fb_done", bus.fb_done, 0);
      chk("abort busy", busy, 0);
      chk("abort overrun", overrun, 0);
      chk("abort wr_count", wr_count, 0);
      chk("abort disp_data", disp_data, 0);
      chk("abort bus", FL_DATA, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort no fb_done", bus.fb_done, 0);
      end
      disp_chk(8'h20);

      // Reset during the drive window frees the bus in that cycle.
      @(posedge clk); #1;
      bus.FL_FLOW  = 1'b1;
      bus.FL_ADDR  = 8'h10;
      bus.fb_start = 1'b1;
      for (int c = 1; c <= LAT + 2; c++) begin
         @(posedge clk); #1 bus.fb_start = 1'b0;
      end
      @(negedge clk);
      chk("drive before rst", FL_DATA, mdl[8'h10]);
      @(posedge clk); #1 RST = 1'b1;
      @(negedge clk);
      chk("bus freed in rst", FL_DATA, 8'hFF);
      @(posedge clk); #1 RST = 1'b0;
      @(negedge clk);
      chk("post rst busy", busy, 0);

      // 260 random writes with interleaved reads: saturation.
      for (int i = 0; i < 260; i++) begin
         ra = 8'($urandom);
         rd = 8'($urandom);
         if (i % 4 == 0) begin
            @(posedge clk); #1 disp_addr = ra;
         end
         run_access(1'b0, ra, rd, 0);
         if (i % 8 == 0) run_access(1'b1, 8'($urandom), 8'h00, 0);
      end
      chk("wr_count sat", wr_count, 8'hFF);
      run_access(1'b0, 8'hFF, 8'h5A, 0);
      run_access(1'b1, 8'hFF, 8'h00, 0);

      for (int a = 0; a < 256; a++) disp_chk(8'(a));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
